// File: rtl/fast_ring_classifier.sv
// FAST ring classifier: takes a centre/threshold header, then 16 circle pixels,
// and emits per-position bright/dark masks on a valid/ready output.
module fast_ring_classifier #(
    parameter int PIX_W  = 8,
    parameter int RING_N = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hdr_valid,
    output logic              hdr_ready,
    input  logic [PIX_W-1:0]  center_pix,
    input  logic [PIX_W-1:0]  threshold,
    input  logic              ring_valid,
    output logic              ring_ready,
    input  logic [PIX_W-1:0]  ring_pix,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RING_N-1:0] bright_mask,
    output logic [RING_N-1:0] dark_mask
);
    // state   | meaning
    // IDLE    | waiting for a candidate header
    // COLLECT | accepting ring beats 0..15
    // OUTPUT  | masks presented, waiting for out_ready

    localparam int CNT_W = 4;

    if (RING_N != 16) begin : g_bad_ring_n
        $error("fast_ring_classifier: RING_N must be 16");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic              rdy_en;
    logic [PIX_W-1:0]  hi, lo;
    logic              bright_off, dark_off;
    logic [CNT_W-1:0]  cnt;
    logic [RING_N-1:0] acc_b, acc_d, acc_b_nxt, acc_d_nxt;

    logic [PIX_W:0]    sum, diff;
    logic [PIX_W-1:0]  hi_nxt, lo_nxt;
    logic              hdr_fire, ring_fire, out_fire, last_beat;
    logic              b_hit, d_hit;

    assign sum    = {1'b0, center_pix} + {1'b0, threshold};
    assign diff   = {1'b0, center_pix} - {1'b0, threshold};
    assign hi_nxt = sum[PIX_W] ? {PIX_W{1'b1}} : sum[PIX_W-1:0];
    assign lo_nxt = diff[PIX_W] ? '0 : diff[PIX_W-1:0];

    // rdy_en keeps hdr_ready low during reset without a path from rst_n
    assign hdr_ready  = rdy_en && (state == ST_IDLE);
    assign ring_ready = (state == ST_COLLECT);

    assign hdr_fire  = hdr_valid && hdr_ready;
    assign ring_fire = ring_valid && ring_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_beat = (cnt == CNT_W'(RING_N - 1));

    assign b_hit     = (ring_pix > hi) && !bright_off;
    assign d_hit     = (ring_pix < lo) && !dark_off;
    assign acc_b_nxt = acc_b | (RING_N'(b_hit) << cnt);
    assign acc_d_nxt = acc_d | (RING_N'(d_hit) << cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (hdr_fire) state_nxt = ST_COLLECT;
            ST_COLLECT: if (ring_fire && last_beat) state_nxt = ST_OUTPUT;
            ST_OUTPUT:  if (out_fire) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en      <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            bright_off  <= 1'b0;
            dark_off    <= 1'b0;
            cnt         <= '0;
            acc_b       <= '0;
            acc_d       <= '0;
            out_valid   <= 1'b0;
            bright_mask <= '0;
            dark_mask   <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (hdr_fire) begin
                hi         <= hi_nxt;
                lo         <= lo_nxt;
                // nothing can exceed a saturated hi, nor fall below a clamped lo
                bright_off <= (sum >= {1'b0, {PIX_W{1'b1}}});
                dark_off   <= (center_pix <= threshold);
                cnt        <= '0;
                acc_b      <= '0;
                acc_d      <= '0;
            end
            if (ring_fire) begin
                acc_b <= acc_b_nxt;
                acc_d <= acc_d_nxt;
                cnt   <= cnt + 1'b1;
                if (last_beat) begin
                    bright_mask <= acc_b_nxt;
                    dark_mask   <= acc_d_nxt;
                    out_valid   <= 1'b1;
                end
            end
            if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
